// File: rtl/instr_encoder_loader_if.sv
// Request handshake plus instruction-memory write bus of the encoder/loader.
// The host/requester uses master; the loader uses slave.
interface instr_encoder_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [12:0]           imm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output req_valid, op, rd, rs1, rs2, imm,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, op, rd, rs1, rs2, imm,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I encoder/program loader: packs ADD/ADDI/BNE field requests into words and
// writes them to consecutive imem addresses. Define CHECKSUM_EN for the running checksum port.
module instr_encoder_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
`ifdef CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } req_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    req_t req;
    logic req_ready;
    logic accept;
    logic legal_wr;
    logic last_wr;

    assign req = '{op: bus.op, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2, imm: bus.imm};

    function automatic logic [DATA_WIDTH-1:0] encode(input req_t r);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        case (r.op)
            2'b00: w = {7'b0, r.rs2, r.rs1, 3'b000, r.rd, 7'b0110011};
            2'b01: w = {r.imm[11:0], r.rs1, 3'b000, r.rd, 7'b0010011};
            // Branch offset is halfword-granular, so imm[0] never reaches the word
            2'b10: w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, 3'b001,
                        r.imm[4:1], r.imm[11], 7'b1100011};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign accept   = bus.req_valid && req_ready;
    assign legal_wr = accept && (req.op != 2'b11);
    assign last_wr  = legal_wr && ((count_q + 1'b1) == FULL_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (start)                   state_d = LOAD;
                else if (finish || last_wr)  state_d = DONE;
            end
            DONE: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; start blocks acceptance so a new session begins clean
    always_comb begin
        busy      = (state_q == LOAD);
        done      = (state_q == DONE);
        req_ready = (state_q == LOAD) && !full_q && !start;
    end

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
`ifdef CHECKSUM_EN
        sum_d   = we_q ? sum_q + wdata_q : sum_q;
`endif
        if (start) begin
            ptr_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
`ifdef CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (legal_wr) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = encode(req);
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            full_d  = last_wr;
        end else if (accept) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign full          = full_q;
    assign err           = err_q;
`ifdef CHECKSUM_EN
    assign checksum      = sum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: two loaders (256-word and 4-word) share one stimulus stream and
// are checked every cycle against a transaction-level model, plus literal spot checks.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, finish, valid;
    logic [1:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    bit          armed = 1'b0;

    int vec_cnt = 0;
    int miss_cnt = 0;

    instr_encoder_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ifa ();
    instr_encoder_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) ifb ();

    assign ifa.req_valid = valid; assign ifb.req_valid = valid;
    assign ifa.op  = op;  assign ifb.op  = op;
    assign ifa.rd  = rd;  assign ifb.rd  = rd;
    assign ifa.rs1 = rs1; assign ifb.rs1 = rs1;
    assign ifa.rs2 = rs2; assign ifb.rs2 = rs2;
    assign ifa.imm = imm; assign ifb.imm = imm;

    logic [8:0] cnt_a;
    logic [2:0] cnt_b;
    logic busy_a, done_a, full_a, err_a, busy_b, done_b, full_b, err_b;
`ifdef CHECKSUM_EN
    logic [31:0] sum_a, sum_b;
`endif

    instr_encoder_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .bus(ifa),
        .count(cnt_a), .busy(busy_a), .done(done_a), .full(full_a),
`ifdef CHECKSUM_EN
        .checksum(sum_a),
`endif
        .err(err_a));

    instr_encoder_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .bus(ifb),
        .count(cnt_b), .busy(busy_b), .done(done_b), .full(full_b),
`ifdef CHECKSUM_EN
        .checksum(sum_b),
`endif
        .err(err_b));

    // DUT outputs gathered per instance for the compare loop
    logic        d_ready [2], d_we [2], d_busy [2], d_done [2], d_full [2], d_err [2];
    logic [31:0] d_addr [2], d_wdata [2], d_cnt [2], d_sum [2];
    assign d_ready[0] = ifa.req_ready; assign d_ready[1] = ifb.req_ready;
    assign d_we[0]    = ifa.mem_we;    assign d_we[1]    = ifb.mem_we;
    assign d_addr[0]  = {24'b0, ifa.mem_addr}; assign d_addr[1] = {30'b0, ifb.mem_addr};
    assign d_wdata[0] = ifa.mem_wdata; assign d_wdata[1] = ifb.mem_wdata;
    assign d_cnt[0]   = {23'b0, cnt_a}; assign d_cnt[1] = {29'b0, cnt_b};
    assign d_busy[0] = busy_a; assign d_busy[1] = busy_b;
    assign d_done[0] = done_a; assign d_done[1] = done_b;
    assign d_full[0] = full_a; assign d_full[1] = full_b;
    assign d_err[0]  = err_a;  assign d_err[1]  = err_b;
`ifdef CHECKSUM_EN
    assign d_sum[0] = sum_a; assign d_sum[1] = sum_b;
`else
    assign d_sum[0] = '0; assign d_sum[1] = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction words from the ISA field layout, built with shifts and masks
    function automatic logic [31:0] enc(input logic [1:0] o, input logic [31:0] d,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] im);
        case (o)
            2'd0: return (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
            2'd1: return ((im & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h13;
            2'd2: return (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (s2 << 20)
                       | (s1 << 15) | (32'd1 << 12) | (((im >> 1) & 15) << 8)
                       | (((im >> 11) & 1) << 7) | 32'h63;
            default: return 32'h0;
        endcase
    endfunction

    // Model: session = {mode, next slot, words written}; one transaction per edge
    int          depth [2] = '{256, 4};
    int          m_mode [2];       // 0 idle, 1 loading, 2 finished
    int          m_slot [2], m_words [2];
    bit          m_we [2], m_err [2];
    logic [31:0] m_addr [2], m_wdata [2], m_sum [2];

    function automatic bit m_ready(input int i);
        return m_mode[i] == 1 && m_words[i] < depth[i] && !start;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0; m_slot[i] = 0; m_words[i] = 0;
                m_we[i] = 0; m_err[i] = 0; m_addr[i] = 0; m_wdata[i] = 0; m_sum[i] = 0;
            end else begin
                bit take;
                take = valid && m_ready(i);
                if (m_we[i]) m_sum[i] = m_sum[i] + m_wdata[i];
                m_we[i] = 0; m_err[i] = 0;
                if (start) begin
                    m_mode[i] = 1; m_slot[i] = 0; m_words[i] = 0; m_sum[i] = 0;
                end else begin
                    if (take && op == 2'd3) m_err[i] = 1;
                    else if (take) begin
                        m_we[i] = 1; m_addr[i] = m_slot[i];
                        m_wdata[i] = enc(op, rd, rs1, rs2, {19'b0, imm});
                        m_slot[i] = (m_slot[i] + 1) % depth[i];
                        m_words[i]++;
                        if (m_words[i] == depth[i]) m_mode[i] = 2;
                    end
                    if (m_mode[i] == 1 && finish) m_mode[i] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("req_ready[%0d]", i), {31'b0, d_ready[i]}, {31'b0, m_ready(i)});
                chk($sformatf("mem_we[%0d]", i), {31'b0, d_we[i]}, {31'b0, m_we[i]});
                if (m_we[i]) begin
                    chk($sformatf("mem_addr[%0d]", i), d_addr[i], m_addr[i]);
                    chk($sformatf("mem_wdata[%0d]", i), d_wdata[i], m_wdata[i]);
                end
                chk($sformatf("count[%0d]", i), d_cnt[i], m_words[i]);
                chk($sformatf("busy[%0d]", i), {31'b0, d_busy[i]}, {31'b0, m_mode[i] == 1});
                chk($sformatf("done[%0d]", i), {31'b0, d_done[i]}, {31'b0, m_mode[i] == 2});
                chk($sformatf("full[%0d]", i), {31'b0, d_full[i]}, {31'b0, m_words[i] == depth[i]});
                chk($sformatf("err[%0d]", i), {31'b0, d_err[i]}, {31'b0, m_err[i]});
`ifdef CHECKSUM_EN
                chk($sformatf("checksum[%0d]", i), d_sum[i], m_sum[i]);
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drv(input bit v, input logic [1:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
        valid = v; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    logic [12:0] full_imm [4] = '{13'h0FFF, 13'h1800, 13'h0001, 13'h07FF};

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        armed = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        chk("reset_count", {23'b0, cnt_a}, 32'd0);
        chk("reset_we", {31'b0, ifa.mem_we}, 32'd0);
        chk("reset_wdata", ifa.mem_wdata, 32'd0);

        // ADDI, ADD, BNE -4, BNE with imm[0] set, back to back
        cyc(); start = 1'b1;
        cyc(); start = 1'b0; drv(1, 2'd1, 5'd1, 5'd0, 5'd0, 13'd5);
        cyc(); drv(1, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        chk("addi_we", {31'b0, ifa.mem_we}, 32'd1);
        chk("addi_addr", {24'b0, ifa.mem_addr}, 32'd0);
        chk("addi_word", ifa.mem_wdata, 32'h00500093);
        chk("addi_count", {23'b0, cnt_a}, 32'd1);
        cyc(); drv(1, 2'd2, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        @(negedge clk);
        chk("add_addr", {24'b0, ifa.mem_addr}, 32'd1);
        chk("add_word", ifa.mem_wdata, 32'h002081B3);
        chk("add_count", {23'b0, cnt_a}, 32'd2);
        cyc(); drv(1, 2'd2, 5'd0, 5'd1, 5'd2, 13'h1FFD);
        @(negedge clk);
        chk("bne_word", ifa.mem_wdata, 32'hFE209EE3);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bne_odd_word", ifa.mem_wdata, 32'hFE209EE3);
        chk("bne_odd_addr", {24'b0, ifa.mem_addr}, 32'd3);
        chk("small_full", {31'b0, full_b}, 32'd1);
        chk("small_done", {31'b0, done_b}, 32'd1);
        chk("small_ready", {31'b0, ifb.req_ready}, 32'd0);

        // Illegal op: handshake completes, err pulse, no write
        cyc(); drv(1, 2'd3, 5'd4, 5'd4, 5'd4, 13'd9);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("illegal_err", {31'b0, err_a}, 32'd1);
        chk("illegal_we", {31'b0, ifa.mem_we}, 32'd0);
        chk("illegal_count", {23'b0, cnt_a}, 32'd4);
        cyc();
        @(negedge clk);
        chk("illegal_err_pulse", {31'b0, err_a}, 32'd0);

        // start beats a simultaneous request, next write lands at address 0
        cyc(); start = 1'b1; drv(1, 2'd1, 5'd5, 5'd5, 5'd0, 13'h0FFF);
        @(negedge clk);
        chk("start_blocks_ready", {31'b0, ifa.req_ready}, 32'd0);
        cyc(); start = 1'b0;
        @(negedge clk);
        chk("start_no_write", {31'b0, ifa.mem_we}, 32'd0);
        chk("start_count", {23'b0, cnt_a}, 32'd0);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("restart_addr", {24'b0, ifa.mem_addr}, 32'd0);
        chk("restart_word", ifa.mem_wdata, 32'hFFF28293);

        // finish with an accepted request: written, then DONE
        cyc(); finish = 1'b1; drv(1, 2'd0, 5'd7, 5'd6, 5'd5, 13'd0);
        cyc(); finish = 1'b0; drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("finish_we", {31'b0, ifa.mem_we}, 32'd1);
        chk("finish_done", {31'b0, done_a}, 32'd1);
        cyc(); drv(1, 2'd1, 5'd1, 5'd1, 5'd0, 13'd1);
        cyc(); cyc();
        @(negedge clk);
        chk("done_hold_count", {23'b0, cnt_a}, 32'd2);
        chk("done_hold_we", {31'b0, ifa.mem_we}, 32'd0);
        drv(0, 0, 0, 0, 0, 0);

        // Fill the 4-word loader, then hold a fifth request until start
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv(1, 2'd1, 5'(k + 1), 5'(k), 5'd0, full_imm[k]);
            cyc();
        end
        drv(1, 2'd1, 5'd9, 5'd9, 5'd0, 13'd1);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("fill_full", {31'b0, full_b}, 32'd1);
        chk("fill_ready", {31'b0, ifb.req_ready}, 32'd0);
        chk("fill_count", {29'b0, cnt_b}, 32'd4);
        chk("fill_we", {31'b0, ifb.mem_we}, 32'd0);
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("refill_we", {31'b0, ifb.mem_we}, 32'd1);
        chk("refill_addr", {30'b0, ifb.mem_addr}, 32'd0);

        // Two-word program, then reset mid-stream
        cyc(); start = 1'b1;
        cyc(); start = 1'b0; drv(1, 2'd1, 5'd1, 5'd0, 5'd0, 13'd5);
        cyc(); drv(1, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        cyc();
`ifdef CHECKSUM_EN
        @(negedge clk);
        chk("checksum_prog", sum_a, 32'h00708246);
`endif
        cyc(); drv(1, 2'd1, 5'd2, 5'd2, 5'd0, 13'd3);
        cyc(); rst_n = 1'b0;
        cyc(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_we", {31'b0, ifa.mem_we}, 32'd0);
        chk("midrst_count", {23'b0, cnt_a}, 32'd0);
        chk("midrst_wdata", ifa.mem_wdata, 32'd0);
        chk("midrst_busy", {31'b0, busy_a}, 32'd0);
`ifdef CHECKSUM_EN
        chk("midrst_checksum", sum_a, 32'd0);
`endif
        cyc(); rst_n = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
